// File: rtl/if_stage_if.sv
// IF-stage pipeline bundle: redirect/hazard controls and instruction fetch in,
// IF/ID register and status out. The slave side is the fetch stage itself.
interface if_stage_if #(
  parameter int PC_W = 9
) ();
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Stall;
  logic            HaltReq;
  logic [31:0]     Inst_In;
  logic [PC_W-1:0] Inst_Addr;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Inst;
  logic            IfId_Valid;
  logic            Halted;
  logic [15:0]     FlushCnt;

  modport master (
    output PcSel, BrPC, Stall, HaltReq, Inst_In,
    input  Inst_Addr, IfId_PC, IfId_Inst, IfId_Valid, Halted, FlushCnt
  );

  modport slave (
    input  PcSel, BrPC, Stall, HaltReq, Inst_In,
    output Inst_Addr, IfId_PC, IfId_Inst, IfId_Valid, Halted, FlushCnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/stall/halt
// handling and a saturating count of taken redirects.
module if_stage #(
  parameter int          PC_W     = 9,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic      clk,
  input  logic      reset_n,
  if_stage_if.slave bus
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            halted_q, halted_d;
  logic [15:0]     flush_cnt_q, flush_cnt_d;
  logic [PC_W-1:0] redirect_pc;
  logic            unused_brpc;

  assign redirect_pc = {bus.BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

  // Priority in RUN: redirect squashes a younger halt/stall, then halt, then stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    flush_cnt_d  = flush_cnt_q;
    if (state_q == RUN) begin
      if (bus.PcSel) begin
        pc_d         = redirect_pc;
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 16'd1;
      end else if (bus.HaltReq) begin
        state_d      = HALTED;
        halted_d     = 1'b1;
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
      end else if (!bus.Stall) begin
        ifid_pc_d    = pc_q;
        ifid_inst_d  = bus.Inst_In;
        ifid_valid_d = 1'b1;
        pc_d         = pc_q + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= RUN;
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.Inst_Addr  = pc_q;
  assign bus.IfId_PC    = ifid_pc_q;
  assign bus.IfId_Inst  = ifid_inst_q;
  assign bus.IfId_Valid = ifid_valid_q;
  assign bus.Halted     = halted_q;
  assign bus.FlushCnt   = flush_cnt_q;

endmodule
